// File: rtl/fsm_tmr_acc_pkg.sv
// ----------------------------------------------------------------------------
// fsm_tmr_acc_pkg
// Shared constants for the triple-modular-redundant accumulator:
//   MODE_XOR / MODE_CLR : encoding of the 'mode' input
//   INJ_NONE            : inj_sel value that selects no copy for corruption
//   DEFAULT_WIDTH       : default state/data width
//   DEFAULT_ERR_CNT_W   : default width of the mismatch counter
// ----------------------------------------------------------------------------
package fsm_tmr_acc_pkg;

    localparam logic       MODE_XOR          = 1'b0;
    localparam logic       MODE_CLR          = 1'b1;
    localparam logic [1:0] INJ_NONE          = 2'd3;
    localparam int         DEFAULT_WIDTH     = 4;
    localparam int         DEFAULT_ERR_CNT_W = 8;

endpackage : fsm_tmr_acc_pkg

// File: rtl/tmr_voter.sv
// ----------------------------------------------------------------------------
// tmr_voter
// Purely combinational bitwise 2-of-3 majority voter.
// Ports:
//   a, b, c : in  [WIDTH-1:0]  the three redundant copies
//   voted   : out [WIDTH-1:0]  per-bit majority of a, b, c
// ----------------------------------------------------------------------------
module tmr_voter #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] voted
);

    assign voted = (a & b) | (b & c) | (a & c);

endmodule : tmr_voter

// File: rtl/fsm_tmr_acc.sv
// ----------------------------------------------------------------------------
// fsm_tmr_acc
// Accumulator whose state is triplicated (r0/r1/r2) and majority-voted every
// cycle. Each edge reloads all three copies from the voted next value, so a
// single upset copy is scrubbed one cycle later. A test-only injection port
// can flip bits in one copy, and a saturating counter tallies mismatch cycles.
// Ports:
//   clk      : in   sole clock, rising edge
//   rst      : in   synchronous active-high reset (highest priority)
//   din      : in   [WIDTH-1:0] data operand
//   en       : in   update enable, 0 holds the voted state
//   mode     : in   MODE_XOR = XOR-accumulate, MODE_CLR = clear bits in din
//   inj_en   : in   fault-injection strobe
//   inj_sel  : in   [1:0] copy to corrupt (0..2), INJ_NONE = no copy
//   inj_mask : in   [WIDTH-1:0] bits flipped in the selected copy
//   err_clr  : in   clears err_cnt
//   data_out : out  [WIDTH-1:0] bitwise inverse of the voted state
//   err      : out  high while any copy disagrees
//   err_cnt  : out  [ERR_CNT_W-1:0] saturating count of mismatch cycles
// ----------------------------------------------------------------------------
module fsm_tmr_acc
    import fsm_tmr_acc_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ERR_CNT_W = DEFAULT_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 inj_en,
    input  logic [1:0]           inj_sel,
    input  logic [WIDTH-1:0]     inj_mask,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     data_out,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    logic [WIDTH-1:0]     r0_q, r0_d;
    logic [WIDTH-1:0]     r1_q, r1_d;
    logic [WIDTH-1:0]     r2_q, r2_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0]     voted;
    logic [WIDTH-1:0]     next_val;

    tmr_voter #(
        .WIDTH (WIDTH)
    ) u_voter (
        .a     (r0_q),
        .b     (r1_q),
        .c     (r2_q),
        .voted (voted)
    );

    // The accumulator always operates on the voted value, never on an
    // individual copy, so a corrupted copy cannot leak into the result.
    always_comb begin
        next_val = voted;
        if (en) begin
            case (mode)
                MODE_XOR: next_val = voted ^ din;
                MODE_CLR: next_val = voted & ~din;
                default:  next_val = voted;
            endcase
        end
    end

    // All copies reload the same next value each edge (scrubbing); the
    // injection port perturbs at most one of them.
    always_comb begin
        r0_d = next_val;
        r1_d = next_val;
        r2_d = next_val;
        if (inj_en && (inj_sel != INJ_NONE)) begin
            case (inj_sel)
                2'd0:    r0_d = next_val ^ inj_mask;
                2'd1:    r1_d = next_val ^ inj_mask;
                2'd2:    r2_d = next_val ^ inj_mask;
                default: r0_d = next_val;
            endcase
        end
    end

    // Two compares are enough: if r0==r1 and r1==r2 then all three agree.
    assign err = (r0_q != r1_q) | (r1_q != r2_q);

    // A clear on a mismatch cycle still records that mismatch, hence the
    // count restarts at err rather than at zero.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = ERR_CNT_W'(err);
        end else if (err && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r0_q      <= '0;
            r1_q      <= '0;
            r2_q      <= '0;
            err_cnt_q <= '0;
        end else begin
            r0_q      <= r0_d;
            r1_q      <= r1_d;
            r2_q      <= r2_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign data_out = ~voted;
    assign err_cnt  = err_cnt_q;

endmodule : fsm_tmr_acc
